pipe_dest_tracker: RTL and testbench
====================================

// Module: pipe_dest_tracker
// PURPOSE
// Producer side of operand forwarding. Carries the destination-register write
// info (rw, memread, Rd) of each in-flight instruction through ID/EX, EX/MEM
// and MEM/WB. Drives the EXMEM_*/MEMWB_* rw/Rd inputs of the forwarding unit.
// Detects load-use hazards and sequences stall, bubble and flush.
// PARAMETERS
// CNT_W   16   width of the saturating stall-cycle counter
// PORTS
// clk_i              in   1      clock, rising edge
// rst_i              in   1      synchronous reset, active-high
// ID_valid_i         in   1      ID stage holds a real instruction
// ID_rw_i            in   1      ID instruction writes the register file
// ID_memread_i       in   1      ID instruction is a load
// ID_Rd_i            in   5      ID destination register (after RegDst select)
// IFID_Rs_i          in   5      ID source register Rs
// IFID_Rt_i          in   5      ID source register Rt
// IFID_uses_rt_i     in   1      Rt is a real source (not an I-type destination)
// flush_i            in   1      branch/jump taken: squash the ID instruction
// mem_stall_i        in   1      data memory busy: freeze the whole pipeline
// IDEX_rw_o          out  1      ID/EX write enable
// IDEX_memread_o     out  1      ID/EX is a load
// IDEX_Rd_o          out  5      ID/EX destination
// EXMEM_rw_o         out  1      EX/MEM write enable (to forwarding unit)
// EXMEM_Rd_o         out  5      EX/MEM destination (to forwarding unit)
// MEMWB_rw_o         out  1      MEM/WB write enable (to forwarding unit, RF)
// MEMWB_Rd_o         out  5      MEM/WB destination (to forwarding unit, RF)
// load_use_o         out  1      combinational load-use hazard flag
// PC_write_o         out  1      PC may update this cycle
// IFID_write_o       out  1      IF/ID may update this cycle
// stall_cnt_o        out  CNT_W  count of stalled cycles (load-use + mem)
// BEHAVIOUR
// - Reset: all rw/memread outputs 0, all Rd outputs 0, stall_cnt_o = 0.
// - load_use = ID_valid_i & IDEX_memread_o & IDEX_rw_o & IDEX_Rd_o!=0 &
//   (IDEX_Rd_o==IFID_Rs_i | (IFID_uses_rt_i & IDEX_Rd_o==IFID_Rt_i)).
// - Per cycle, priority is mem_stall_i > flush_i > load_use > normal.
// - mem_stall_i=1: all three stages hold their values. PC_write_o=0,
//   IFID_write_o=0. load_use_o still reports the hazard.
// - flush_i=1: ID/EX loads a bubble (rw=0, memread=0, Rd=0). EX/MEM and
//   MEM/WB advance. PC_write_o=1, IFID_write_o=1. Flush overrides load_use.
// - load_use (no flush, no mem_stall): ID/EX loads a bubble. EX/MEM and
//   MEM/WB advance. PC_write_o=0, IFID_write_o=0.
// - normal: ID/EX <= (ID_valid_i & ID_rw_i, ID_valid_i & ID_memread_i,
//   ID_valid_i ? ID_Rd_i : 0). EX/MEM <= ID/EX. MEM/WB <= EX/MEM.
//   PC_write_o=1, IFID_write_o=1.
// - A bubble always has Rd=0, so it never matches in forwarding.
// - One load causes exactly one load-use bubble. The cycle after the bubble,
//   the load is in EX/MEM and is forwarded from there.
// - Rd=0 writes are propagated unchanged. Downstream logic ignores $0.
// - stall_cnt_o increments by 1 when (mem_stall_i | load_use) & ~flush_i.
//   It saturates at all-ones. There is no wrap-around.
// - rst_i overrides everything, including a freeze in progress. Outputs take
//   reset values on the next edge.
// TESTING
// - lw $8 in ID, next add $9,$8,$1 -> 1 cycle load_use_o=1, PC_write_o=0,
//   IDEX_rw_o=0 the next cycle, then EXMEM_Rd_o=8 with EXMEM_rw_o=1.
// - lw $0 followed by a reader of $0 -> no stall, load_use_o=0.
// - load_use together with flush_i=1 -> PC_write_o=1, ID/EX bubble,
//   stall_cnt_o unchanged.
// - add $5 then mem_stall_i=1 for 3 cycles -> EXMEM_Rd_o=5 held 3 cycles,
//   stall_cnt_o +3.
// - Force stall_cnt_o to all-ones, then stall again -> stays all-ones.
// - rst_i asserted during mem_stall_i -> all outputs 0 after the next edge,
//   PC_write_o=1.

Source files
------------

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: carries destination-register write info (rw, memread, Rd)
// through ID/EX, EX/MEM and MEM/WB for the forwarding unit, detects load-use
// hazards, and sequences the stall, bubble and flush behaviour.
//
// Flow control: ID_valid_i qualifies the ID-stage fields for one cycle. The
// ID instruction is consumed on a rising edge only when IFID_write_o is 1;
// while IFID_write_o is 0 the upstream stage must hold its values, and they
// are presented again on the following cycle.
module pipe_dest_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_valid_i,
  input  logic             ID_rw_i,
  input  logic             ID_memread_i,
  input  logic [4:0]       ID_Rd_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             IFID_uses_rt_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             IDEX_rw_o,
  output logic             IDEX_memread_o,
  output logic [4:0]       IDEX_Rd_o,
  output logic             EXMEM_rw_o,
  output logic [4:0]       EXMEM_Rd_o,
  output logic             MEMWB_rw_o,
  output logic [4:0]       MEMWB_Rd_o,
  output logic             load_use_o,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic rs_match;
  logic rt_match;
  logic hazard;
  logic bubble;
  logic count_en;

  // A load in ID/EX whose nonzero destination feeds an ID source cannot be
  // forwarded in time; that ID instruction must wait one cycle.
  always_comb begin
    rs_match = (IDEX_Rd_o == IFID_Rs_i);
    rt_match = IFID_uses_rt_i & (IDEX_Rd_o == IFID_Rt_i);
    hazard   = ID_valid_i & IDEX_memread_o & IDEX_rw_o &
               (IDEX_Rd_o != 5'd0) & (rs_match | rt_match);
  end

  assign load_use_o = hazard;

  // Front-end write enables: a memory freeze wins, then a flush lets the
  // front end move on (the hazard instruction is being squashed anyway),
  // otherwise a hazard holds PC and IF/ID.
  assign PC_write_o   = ~mem_stall_i & (flush_i | ~hazard);
  assign IFID_write_o = ~mem_stall_i & (flush_i | ~hazard);

  // Both a flush and a hazard insert a bubble into ID/EX when not frozen.
  assign bubble   = flush_i | hazard;
  assign count_en = (mem_stall_i | hazard) & ~flush_i;

  // Stage registers: frozen on a memory stall, otherwise shift down with
  // either the ID instruction or a bubble entering ID/EX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      IDEX_rw_o      <= 1'b0;
      IDEX_memread_o <= 1'b0;
      IDEX_Rd_o      <= 5'd0;
      EXMEM_rw_o     <= 1'b0;
      EXMEM_Rd_o     <= 5'd0;
      MEMWB_rw_o     <= 1'b0;
      MEMWB_Rd_o     <= 5'd0;
    end else if (!mem_stall_i) begin
      MEMWB_rw_o <= EXMEM_rw_o;
      MEMWB_Rd_o <= EXMEM_Rd_o;
      EXMEM_rw_o <= IDEX_rw_o;
      EXMEM_Rd_o <= IDEX_Rd_o;
      if (bubble) begin
        IDEX_rw_o      <= 1'b0;
        IDEX_memread_o <= 1'b0;
        IDEX_Rd_o      <= 5'd0;
      end else begin
        IDEX_rw_o      <= ID_valid_i & ID_rw_i;
        IDEX_memread_o <= ID_valid_i & ID_memread_i;
        IDEX_Rd_o      <= ID_valid_i ? ID_Rd_i : 5'd0;
      end
    end
  end

  // Saturating count of stalled cycles; holds at all-ones once reached.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (count_en && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// tb_pipe_dest_tracker: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_pipe_dest_tracker;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int VW      = 22 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             id_valid = 1'b0, id_rw = 1'b0, id_memread = 1'b0;
  logic [4:0]       id_rd = 5'd0, rs = 5'd0, rt = 5'd0;
  logic             uses_rt = 1'b0, flush = 1'b0, mem_stall = 1'b0;

  logic             idex_rw, idex_memread, exmem_rw, memwb_rw;
  logic [4:0]       idex_rd, exmem_rd, memwb_rd;
  logic             load_use, pc_write, ifid_write;
  logic [CNT_W-1:0] stall_cnt;

  pipe_dest_tracker #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_valid_i(id_valid), .ID_rw_i(id_rw), .ID_memread_i(id_memread),
    .ID_Rd_i(id_rd), .IFID_Rs_i(rs), .IFID_Rt_i(rt), .IFID_uses_rt_i(uses_rt),
    .flush_i(flush), .mem_stall_i(mem_stall),
    .IDEX_rw_o(idex_rw), .IDEX_memread_o(idex_memread), .IDEX_Rd_o(idex_rd),
    .EXMEM_rw_o(exmem_rw), .EXMEM_Rd_o(exmem_rd),
    .MEMWB_rw_o(memwb_rw), .MEMWB_Rd_o(memwb_rd),
    .load_use_o(load_use), .PC_write_o(pc_write), .IFID_write_o(ifid_write),
    .stall_cnt_o(stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // Pipeline as a list of in-flight instructions: index 0 = ID/EX,
  // 1 = EX/MEM, 2 = MEM/WB. Each slot is {rw, memread, rd}.
  logic       p_rw [3];
  logic       p_mr [3];
  logic [4:0] p_rd [3];
  int         m_cnt;

  logic [VW-1:0] exp_q[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      p_rw[i] = 1'b0; p_mr[i] = 1'b0; p_rd[i] = 5'd0;
    end
    m_cnt = 0;
  end

  // ---------------- driver ----------------
  // One cycle: apply inputs just after the edge, record what the outputs must
  // be during this cycle, then advance the model to the next edge.
  task automatic step(input logic v, input logic w, input logic mr,
                      input logic [4:0] d, input logic [4:0] s,
                      input logic [4:0] t, input logic urt,
                      input logic fl, input logic ms, input logic r);
    logic hz, fwd;
    @(posedge clk);
    #1;
    id_valid = v; id_rw = w; id_memread = mr; id_rd = d;
    rs = s; rt = t; uses_rt = urt; flush = fl; mem_stall = ms; rst = r;

    hz  = v && p_mr[0] && p_rw[0] && p_rd[0] != 0 &&
          (p_rd[0] == s || (urt && p_rd[0] == t));
    fwd = !ms && (fl || !hz);
    exp_q.push_back({p_rw[0], p_mr[0], p_rd[0], p_rw[1], p_rd[1],
                     p_rw[2], p_rd[2], hz, fwd, fwd, CNT_W'(m_cnt)});

    if (r) begin
      for (int i = 0; i < 3; i++) begin
        p_rw[i] = 1'b0; p_mr[i] = 1'b0; p_rd[i] = 5'd0;
      end
      m_cnt = 0;
    end else begin
      if (!ms) begin
        p_rw[2] = p_rw[1]; p_rd[2] = p_rd[1];
        p_rw[1] = p_rw[0]; p_rd[1] = p_rd[0];
        if (fl || hz) begin
          p_rw[0] = 1'b0; p_mr[0] = 1'b0; p_rd[0] = 5'd0;
        end else begin
          p_rw[0] = v & w; p_mr[0] = v & mr; p_rd[0] = v ? d : 5'd0;
        end
      end
      if ((ms || hz) && !fl && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic nop(input logic ms);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ms, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [VW-1:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {idex_rw, idex_memread, idex_rd, exmem_rw, exmem_rd,
           memwb_rw, memwb_rd, load_use, pc_write, ifid_write, stall_cnt};
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL cycle_compare @%0t: got %h expected %h", $time, g, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    nop(1'b0);
    @(negedge clk);
    check("reset_idex_rw", int'(idex_rw), 0);
    check("reset_memwb_rd", int'(memwb_rd), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    check("reset_pc_write", int'(pc_write), 1);

    // lw $8 ; add $9,$8,$1
    step(1'b1, 1'b1, 1'b1, 5'd8, 5'd2, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_flag", int'(load_use), 1);
    check("lu_pc_write", int'(pc_write), 0);
    check("lu_ifid_write", int'(ifid_write), 0);
    step(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_bubble_rw", int'(idex_rw), 0);
    check("lu_bubble_rd", int'(idex_rd), 0);
    check("lu_exmem_rd", int'(exmem_rd), 8);
    check("lu_exmem_rw", int'(exmem_rw), 1);
    check("lu_released", int'(load_use), 0);
    check("lu_cnt", int'(stall_cnt), 1);

    // lw $0 ; reader of $0
    step(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("r0_no_hazard", int'(load_use), 0);
    check("r0_pc_write", int'(pc_write), 1);

    // load-use coinciding with flush
    step(1'b1, 1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 5'd6, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_flag", int'(load_use), 1);
    check("fl_pc_write", int'(pc_write), 1);
    nop(1'b0);
    @(negedge clk);
    check("fl_bubble_rw", int'(idex_rw), 0);
    check("fl_bubble_mr", int'(idex_memread), 0);
    check("fl_cnt", int'(stall_cnt), 1);

    // add $5 then a 3-cycle memory freeze
    step(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(1'b0);
    for (int i = 0; i < 3; i++) begin
      nop(1'b1);
      @(negedge clk);
      check("ms_exmem_rd", int'(exmem_rd), 5);
      check("ms_pc_write", int'(pc_write), 0);
    end
    nop(1'b0);
    @(negedge clk);
    check("ms_exmem_rd_after", int'(exmem_rd), 5);
    check("ms_cnt", int'(stall_cnt), 4);

    // saturation
    for (int i = 0; i < CNT_MAX + 4; i++) nop(1'b1);
    nop(1'b0);
    @(negedge clk);
    check("sat_cnt", int'(stall_cnt), CNT_MAX);
    nop(1'b1);
    nop(1'b0);
    @(negedge clk);
    check("sat_hold", int'(stall_cnt), CNT_MAX);

    // reset during a freeze
    step(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(1'b0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    nop(1'b0);
    @(negedge clk);
    check("rst_ms_exmem_rw", int'(exmem_rw), 0);
    check("rst_ms_exmem_rd", int'(exmem_rd), 0);
    check("rst_ms_cnt", int'(stall_cnt), 0);
    check("rst_ms_pc_write", int'(pc_write), 1);

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 63) == 0));
    end
    nop(1'b0);
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
